// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: pcSel encoding, sequencer FSM states, reset PC.
// With JR_ALIGN_CHECK_EN defined the FSM gains a terminal halt state for misaligned jr.
package mips_pkg;

    // pcSel encoding driven by the main controller.
    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_JUMP   = 2'd1;
    localparam logic [1:0] PC_JR     = 2'd2;
    localparam logic [1:0] PC_BRANCH = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StIssue
`ifdef JR_ALIGN_CHECK_EN
        ,
        StHalt
`endif
    } seq_state_e;

    // Sign-extended, word-scaled branch displacement.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch/issue bundle between the PC sequencer (master) and its environment (slave):
// instruction-memory request/response, decode handshake, controller inputs, PC outputs.
// misalign_err exists only with JR_ALIGN_CHECK_EN.
interface pc_sequencer_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [1:0]  pc_sel;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
`ifdef JR_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    modport master (
`ifdef JR_ALIGN_CHECK_EN
        output misalign_err,
`endif
        output imem_req_valid, imem_req_addr, instr_valid, instr, pc, pc_plus4,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_sel, jr_target
    );

    modport slave (
`ifdef JR_ALIGN_CHECK_EN
        input  misalign_err,
`endif
        input  imem_req_valid, imem_req_addr, instr_valid, instr, pc, pc_plus4,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_sel, jr_target
    );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC target selection from the held PC/instruction and pcSel.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] instr_i,
    input  logic [1:0]  pc_sel_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] pc_plus4_o,
    output logic [31:0] next_pc_o
);

    logic [31:0] plus4;

    assign plus4      = pc_i + 32'd4;
    assign pc_plus4_o = plus4;

    // Target mux; all arithmetic wraps modulo 2^32.
    always_comb begin
        next_pc_o = plus4;
        case (pc_sel_i)
            PC_SEQ:    next_pc_o = plus4;
            PC_JUMP:   next_pc_o = {plus4[31:28], instr_i, 2'b00};
            PC_JR:     next_pc_o = jr_target_i;
            PC_BRANCH: next_pc_o = plus4 + branch_offset(instr_i[15:0]);
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-fetch and next-PC sequencer: FETCH -> WAIT -> ISSUE, one outstanding fetch.
// Optional JR_ALIGN_CHECK_EN: a misaligned jr target halts the sequencer until reset.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = RESET_PC_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       next_pc;
    logic [31:0]       pc_plus4;
`ifdef JR_ALIGN_CHECK_EN
    logic              misalign_q, misalign_d;
`endif

    next_pc_calc u_next_pc_calc (
        .pc_i        (pc_q),
        .instr_i     (instr_q[25:0]),
        .pc_sel_i    (bus.pc_sel),
        .jr_target_i (bus.jr_target),
        .pc_plus4_o  (pc_plus4),
        .next_pc_o   (next_pc)
    );

    // State, PC, held instruction and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
`ifdef JR_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
`ifdef JR_ALIGN_CHECK_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // Next-state logic; PC and instruction only move on their own handshakes.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
`ifdef JR_ALIGN_CHECK_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            StFetch: begin
                if (bus.imem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.imem_rsp_valid) begin
                    instr_d = bus.imem_rsp_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.instr_ready) begin
`ifdef JR_ALIGN_CHECK_EN
                    if (bus.pc_sel == PC_JR && bus.jr_target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                        state_d    = StHalt;
                    end else begin
                        pc_d    = next_pc;
                        state_d = StFetch;
                    end
`else
                    pc_d    = next_pc;
                    state_d = StFetch;
`endif
                end
            end
`ifdef JR_ALIGN_CHECK_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Request valid is forced low while reset is held, even though the state reads FETCH.
    assign bus.imem_req_valid = rst_n && (state_q == StFetch);
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = (state_q == StIssue);
    assign bus.instr          = instr_q;
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_plus4;
`ifdef JR_ALIGN_CHECK_EN
    assign bus.misalign_err   = misalign_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan cases, then randomized
// instruction streams against a transaction-level next-PC model.
module tb_pc_sequencer;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] exp_pc;
    logic [31:0] last_instr;
    bit          halted;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Architectural next-PC rule from pcSel, in plain arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] word,
                                             input logic [1:0] sel, input logic [31:0] jr);
        logic [31:0] link;
        int          off;
        link = cur + 32'd4;
        off  = int'($signed(word[15:0]));
        case (sel)
            2'd0:    return link;
            2'd1:    return (link & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
            2'd2:    return jr;
            default: return link + 32'(off * 4);
        endcase
    endfunction

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b0;
        bus.pc_sel         = PC_SEQ;
        bus.jr_target      = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #1;
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_instr", bus.instr, 32'd0);
        check_eq("rst_pc", bus.pc, RST_PC);
`ifdef JR_ALIGN_CHECK_EN
        check_eq("rst_misalign", 32'(bus.misalign_err), 32'd0);
`endif
        tick();
        tick();
        check_eq("rst_req_valid_held", 32'(bus.imem_req_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        exp_pc     = RST_PC;
        last_instr = 32'd0;
        halted     = 1'b0;
    endtask

    // One full fetch/issue exchange with the given stall profile; updates the model.
    task automatic do_instr(input logic [31:0] word, input logic [1:0] sel,
                            input logic [31:0] jr, input int req_stall, input int rsp_delay,
                            input int iss_stall, input bit stray);
        int start;
        start = cyc;
        for (int i = 0; i <= req_stall; i++) begin
            check_eq("fetch_req_valid", 32'(bus.imem_req_valid), 32'd1);
            check_eq("fetch_instr_valid", 32'(bus.instr_valid), 32'd0);
            check_eq("fetch_addr", bus.imem_req_addr, exp_pc);
            check_eq("fetch_instr_held", bus.instr, last_instr);
            bus.imem_req_ready = (i == req_stall);
            bus.imem_rsp_valid = stray && (i < req_stall);
            bus.imem_rsp_data  = $urandom;
            tick();
        end
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        for (int i = 0; i <= rsp_delay; i++) begin
            check_eq("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
            check_eq("wait_instr_valid", 32'(bus.instr_valid), 32'd0);
            bus.imem_rsp_valid = (i == rsp_delay);
            bus.imem_rsp_data  = (i == rsp_delay) ? word : $urandom;
            tick();
        end
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = $urandom;
        for (int i = 0; i <= iss_stall; i++) begin
            check_eq("issue_instr_valid", 32'(bus.instr_valid), 32'd1);
            check_eq("issue_req_valid", 32'(bus.imem_req_valid), 32'd0);
            check_eq("issue_instr", bus.instr, word);
            check_eq("issue_pc", bus.pc, exp_pc);
            check_eq("issue_pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
            bus.instr_ready = (i == iss_stall);
            bus.pc_sel      = (i == iss_stall) ? sel : 2'($urandom);
            bus.jr_target   = (i == iss_stall) ? jr : $urandom;
            tick();
        end
        bus.instr_ready = 1'b0;
        check_eq("instr_cycles", 32'(cyc - start), 32'(3 + req_stall + rsp_delay + iss_stall));
`ifdef JR_ALIGN_CHECK_EN
        if (sel == PC_JR && jr[1:0] != 2'b00) begin
            halted = 1'b1;
        end else begin
            exp_pc = ref_next(exp_pc, word, sel, jr);
        end
`else
        exp_pc = ref_next(exp_pc, word, sel, jr);
`endif
        last_instr = word;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        exp_pc     = RST_PC;
        last_instr = 32'd0;
        halted     = 1'b0;
        #2;
        do_reset();

        // Back-to-back sequential fetches at minimum latency.
        for (int i = 0; i < 3; i++) do_instr($urandom, PC_SEQ, 32'd0, 0, 0, 0, 1'b0);

        // Branch taken and not taken from pc=0x100.
        do_instr($urandom, PC_JR, 32'h0000_0100, 0, 0, 0, 1'b0);
        do_instr(32'h1000_FFFE, PC_BRANCH, 32'd0, 0, 0, 0, 1'b0);
        check_eq("branch_target_fetch", bus.imem_req_addr, 32'h0000_00FC);
        do_instr($urandom, PC_JR, 32'h0000_0100, 0, 0, 0, 1'b0);
        do_instr(32'h1000_FFFE, PC_SEQ, 32'd0, 0, 0, 0, 1'b0);
        check_eq("branch_not_taken_fetch", bus.imem_req_addr, 32'h0000_0104);

        // Jump within the 256 MB region.
        do_instr($urandom, PC_JR, 32'h4000_0010, 0, 0, 0, 1'b0);
        do_instr(32'h0800_0040, PC_JUMP, 32'd0, 0, 1, 0, 1'b0);
        check_eq("jump_target_fetch", bus.imem_req_addr, 32'h4000_0100);

        // jr with a five-cycle decode stall.
        do_instr($urandom, PC_JR, 32'h0000_2000, 0, 0, 5, 1'b0);
        check_eq("jr_target_fetch", bus.imem_req_addr, 32'h0000_2000);

        // Request backpressure with stray responses during FETCH.
        do_instr($urandom, PC_SEQ, 32'd0, 4, 2, 1, 1'b1);

        // Reset asserted while waiting for a response.
        check_eq("pre_wait_req_valid", 32'(bus.imem_req_valid), 32'd1);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        check_eq("in_wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        do_reset();
        do_instr($urandom, PC_SEQ, 32'd0, 2, 0, 0, 1'b1);

`ifdef JR_ALIGN_CHECK_EN
        do_instr($urandom, PC_JR, 32'h0000_2000, 0, 0, 0, 1'b0);
        do_instr($urandom, PC_JR, 32'h0000_2002, 0, 0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq("halt_misalign", 32'(bus.misalign_err), 32'd1);
            check_eq("halt_req_valid", 32'(bus.imem_req_valid), 32'd0);
            check_eq("halt_instr_valid", 32'(bus.instr_valid), 32'd0);
            check_eq("halt_pc", bus.pc, 32'h0000_2000);
            bus.imem_req_ready = 1'($urandom);
            bus.imem_rsp_valid = 1'($urandom);
            bus.instr_ready    = 1'b1;
            tick();
        end
        do_reset();
`else
        do_instr($urandom, PC_JR, 32'h0000_2002, 0, 0, 0, 1'b0);
        check_eq("jr_unaligned_fetch", bus.imem_req_addr, 32'h0000_2002);
        do_instr($urandom, PC_JR, 32'h0000_0000, 0, 0, 0, 1'b0);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] w;
            logic [31:0] jr;
            logic [1:0]  sel;
            w   = $urandom;
            sel = 2'($urandom_range(0, 3));
            jr  = $urandom;
`ifdef JR_ALIGN_CHECK_EN
            jr  = jr & 32'hFFFF_FFFC;
`endif
            do_instr(w, sel, jr, $urandom_range(0, 2), $urandom_range(0, 2),
                     $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
